// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    localparam logic [7:0]   HEADER_DEFAULT = 8'hA5;
    localparam int unsigned  WORD_W         = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/checksum8.sv
// 8-bit XOR accumulator; clear has priority over en.
module checksum8 (
    input  logic       CLK,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum ^ din;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames bytes into 16-bit words, writes instruction
// memory and releases the core only after a matching XOR checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter logic [7:0]  HEADER = HEADER_DEFAULT
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_din,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned WC_W      = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    state_t          state_q, state_d;
    logic [7:0]      len_hi_q;
    logic [7:0]      hi_q;
    logic [WC_W-1:0] len_q;
    logic [7:0]      chk_sum;

    logic            accept;
    logic [15:0]     n_full;
    logic            len_bad;
    logic            last_word;

    logic            start_c, take_len_hi_c, load_len_c, len_fail_c;
    logic            take_hi_c, take_lo_c, do_write_c, chk_good_c, chk_bad_c;

    assign accept    = rx_valid & rx_ready;
    assign n_full    = {len_hi_q, rx_data};
    assign len_bad   = (n_full == 16'd0) || (32'(n_full) > MAX_WORDS);
    assign last_word = (word_count + WC_W'(1)) == len_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        start_c       = 1'b0;
        take_len_hi_c = 1'b0;
        load_len_c    = 1'b0;
        len_fail_c    = 1'b0;
        take_hi_c     = 1'b0;
        take_lo_c     = 1'b0;
        do_write_c    = 1'b0;
        chk_good_c    = 1'b0;
        chk_bad_c     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && rx_data == HEADER) begin
                    state_d = S_LEN_HI;
                    start_c = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    state_d       = S_LEN_LO;
                    take_len_hi_c = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_bad) begin
                        state_d    = S_ERR;
                        len_fail_c = 1'b1;
                    end else begin
                        state_d    = S_DATA_HI;
                        load_len_c = 1'b1;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    state_d   = S_DATA_LO;
                    take_hi_c = 1'b1;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    state_d   = S_WRITE;
                    take_lo_c = 1'b1;
                end
            end
            S_WRITE: begin
                do_write_c = 1'b1;
                state_d    = last_word ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: begin
                if (accept) begin
                    if (rx_data == chk_sum) begin
                        state_d    = S_DONE;
                        chk_good_c = 1'b1;
                    end else begin
                        state_d    = S_ERR;
                        chk_bad_c  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, all keyed off the FSM strobes.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rx_ready   <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            len_hi_q   <= '0;
            hi_q       <= '0;
            len_q      <= '0;
        end else begin
            rx_ready <= (state_d != S_WRITE);
            mem_we   <= (state_d == S_WRITE);
            if (take_len_hi_c) len_hi_q <= rx_data;
            if (take_hi_c)     hi_q     <= rx_data;
            if (take_lo_c)     mem_din  <= {hi_q, rx_data};
            if (load_len_c) begin
                len_q      <= WC_W'(n_full);
                mem_addr   <= '0;
                word_count <= '0;
            end
            // Address wraps after the 2^ADDR_W-th word; the wrapped value is never written.
            if (do_write_c) begin
                mem_addr   <= mem_addr + ADDR_W'(1);
                word_count <= word_count + WC_W'(1);
            end
            if (start_c) begin
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
            end
            if (chk_good_c) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (chk_bad_c || len_fail_c) error <= 1'b1;
        end
    end

    checksum8 u_checksum (
        .CLK   (CLK),
        .reset (reset),
        .clear (load_len_c),
        .en    (take_hi_c | take_lo_c),
        .din   (rx_data),
        .sum   (chk_sum)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: cycle-accurate vector table plus
// hand-written sequences for mid-load reset and a full-size 4096-word load.
module tb_prog_loader;

    logic        CLK;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_din;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [12:0] word_count;

    prog_loader dut (
        .CLK        (CLK),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: mem_we is high for one full cycle, sampled on the falling edge.
    logic [15:0] tb_mem [0:4095];
    int          wr_cnt    = 0;
    logic [11:0] last_addr = '0;
    always @(negedge CLK) begin
        if (mem_we) begin
            tb_mem[mem_addr] = mem_din;
            wr_cnt           = wr_cnt + 1;
            last_addr        = mem_addr;
        end
    end

    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [11:0] addr;
        logic [15:0] din;
        logic        hold;
        logic        dn;
        logic        er;
        logic [12:0] wc;
    } vec_t;

    vec_t vecs[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic rdy, input logic we,
                       input logic [11:0] addr, input logic [15:0] din, input logic hold,
                       input logic dn, input logic er, input logic [12:0] wc);
        vec_t r;
        r = '{v:v, d:d, rdy:rdy, we:we, addr:addr, din:din, hold:hold, dn:dn, er:er, wc:wc};
        vecs.push_back(r);
    endtask

    // Shorthands: b = accepted/stalled byte, no write; w = byte presented during a WRITE cycle.
    task automatic b(input logic [7:0] d, input logic hold, input logic dn, input logic er,
                     input logic [12:0] wc);
        add(1'b1, d, 1'b1, 1'b0, 12'h0, 16'h0, hold, dn, er, wc);
    endtask

    task automatic w(input logic [7:0] d, input logic [11:0] a, input logic [15:0] din,
                     input logic [12:0] wc);
        add(1'b1, d, 1'b0, 1'b1, a, din, 1'b1, 1'b0, 1'b0, wc);
    endtask

    function automatic logic [63:0] pack_obs(input logic rdy, input logic we, input logic hold,
                                             input logic dn, input logic er, input logic [12:0] wc,
                                             input logic [11:0] addr, input logic [15:0] din);
        return 64'({rdy, we, hold, dn, er, wc, we ? addr : 12'h0, we ? din : 16'h0});
    endfunction

    task automatic send_byte(input logic [7:0] d);
        int n;
        n        = 0;
        rx_valid = 1'b1;
        rx_data  = d;
        while (!rx_ready && n < 8) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!rx_ready) begin
            nerr++;
            $display("FAIL ready_timeout: rx_ready stuck at 0 for byte %h", d);
        end
        @(posedge CLK); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        int          wr_start;
        logic [7:0]  chk;
        logic [7:0]  hi;
        logic [7:0]  lo;

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_obs", pack_obs(rx_ready, mem_we, cpu_hold, done, error, word_count, 12'h0, 16'h0),
              pack_obs(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 13'd0, 12'h0, 16'h0));
        check("reset_addr_din", 64'({mem_addr, mem_din}), 64'({12'h0, 16'h0}));
        reset = 1'b1;
        @(posedge CLK); #1;

        // Non-header byte is dropped in IDLE.
        b(8'h33, 1, 0, 0, 0);
        // Good two-word frame, rx_valid held continuously.
        b(8'hA5, 1, 0, 0, 0); b(8'h00, 1, 0, 0, 0); b(8'h02, 1, 0, 0, 0);
        b(8'h12, 1, 0, 0, 0); w(8'h34, 12'd0, 16'h1234, 0);
        b(8'hAB, 1, 0, 0, 1); b(8'hAB, 1, 0, 0, 1); w(8'hCD, 12'd1, 16'hABCD, 1);
        b(8'h40, 1, 0, 0, 2); b(8'h40, 0, 1, 0, 2);
        add(1'b0, 8'h00, 1'b1, 1'b0, 12'h0, 16'h0, 0, 1, 0, 2);
        b(8'h12, 0, 1, 0, 2);
        // Same frame, wrong checksum.
        b(8'hA5, 1, 0, 0, 2); b(8'h00, 1, 0, 0, 2); b(8'h02, 1, 0, 0, 0);
        b(8'h12, 1, 0, 0, 0); w(8'h34, 12'd0, 16'h1234, 0);
        b(8'hAB, 1, 0, 0, 1); b(8'hAB, 1, 0, 0, 1); w(8'hCD, 12'd1, 16'hABCD, 1);
        b(8'h41, 1, 0, 0, 2); b(8'h41, 1, 0, 1, 2);
        // Zero length.
        b(8'hA5, 1, 0, 0, 2); b(8'h00, 1, 0, 0, 2); b(8'h00, 1, 0, 1, 2);
        // One word FF00, checksum FF.
        b(8'hA5, 1, 0, 0, 2); b(8'h00, 1, 0, 0, 2); b(8'h01, 1, 0, 0, 0);
        b(8'hFF, 1, 0, 0, 0); w(8'h00, 12'd0, 16'hFF00, 0);
        b(8'hFF, 1, 0, 0, 1); b(8'hFF, 0, 1, 0, 1);
        // Three words with continuous rx_valid, checksum 07.
        b(8'hA5, 1, 0, 0, 1); b(8'h00, 1, 0, 0, 1); b(8'h03, 1, 0, 0, 0);
        b(8'h01, 1, 0, 0, 0); w(8'h02, 12'd0, 16'h0102, 0);
        b(8'h03, 1, 0, 0, 1); b(8'h03, 1, 0, 0, 1); w(8'h04, 12'd1, 16'h0304, 1);
        b(8'h05, 1, 0, 0, 2); b(8'h05, 1, 0, 0, 2); w(8'h06, 12'd2, 16'h0506, 2);
        b(8'h07, 1, 0, 0, 3); b(8'h07, 0, 1, 0, 3);
        // Length 4097 exceeds memory.
        b(8'hA5, 1, 0, 0, 3); b(8'h10, 1, 0, 0, 3); b(8'h01, 1, 0, 1, 3);
        add(1'b0, 8'h00, 1'b1, 1'b0, 12'h0, 16'h0, 1, 0, 1, 3);

        foreach (vecs[i]) begin
            rx_valid = vecs[i].v;
            rx_data  = vecs[i].d;
            @(posedge CLK); #1;
            check($sformatf("vec%0d", i),
                  pack_obs(rx_ready, mem_we, cpu_hold, done, error, word_count, mem_addr, mem_din),
                  pack_obs(vecs[i].rdy, vecs[i].we, vecs[i].hold, vecs[i].dn, vecs[i].er,
                           vecs[i].wc, vecs[i].addr, vecs[i].din));
        end
        rx_valid = 1'b0;

        // Reset asserted while the first word is being written.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        check("midload_we_before_reset", 64'(mem_we), 64'(1'b1));
        reset = 1'b0;
        #1;
        check("midload_async_reset",
              pack_obs(rx_ready, mem_we, cpu_hold, done, error, word_count, 12'h0, 16'h0),
              pack_obs(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 13'd0, 12'h0, 16'h0));
        check("midload_addr_din", 64'({mem_addr, mem_din}), 64'({12'h0, 16'h0}));
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK); #1;

        // Complete frame after the aborted one: DEAD BEEF, checksum 22.
        wr_start = wr_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h22);
        check("recover_status", 64'({done, error, cpu_hold, word_count}),
              64'({1'b1, 1'b0, 1'b0, 13'd2}));
        check("recover_writes", 64'(wr_cnt - wr_start), 64'(2));
        check("recover_mem", 64'({tb_mem[0], tb_mem[1]}), 64'({16'hDEAD, 16'hBEEF}));

        // Full-size load of 4096 words.
        wr_start = wr_cnt;
        chk      = 8'h00;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
        for (int i = 0; i < 4096; i++) begin
            hi  = 8'(i >> 8) ^ 8'h3C;
            lo  = 8'(i);
            chk = chk ^ hi ^ lo;
            send_byte(hi);
            send_byte(lo);
        end
        check("full_hold_before_chk", 64'({cpu_hold, done}), 64'({1'b1, 1'b0}));
        send_byte(chk);
        check("full_status", 64'({done, error, cpu_hold, word_count}),
              64'({1'b1, 1'b0, 1'b0, 13'd4096}));
        check("full_writes", 64'(wr_cnt - wr_start), 64'(4096));
        check("full_last_addr", 64'(last_addr), 64'(12'd4095));
        check("full_mem_ends", 64'({tb_mem[0], tb_mem[2049], tb_mem[4095]}),
              64'({16'h3C00, 16'h3401, 16'h33FF}));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d vectors applied", nvec);
        $fatal(1, "timeout");
    end

endmodule
